key_controller: RTL and testbench

- Upstream stage for the stopwatch/timer counter; it converts the two raw active-low push-buttons into clean control state.
- It synchronises and debounces KEY[1:0], then derives: start/stop run flag, clear pulse, timer/stopwatch mode flag (long press), and status LEDs.
- Its outputs drive the counter block's run/clear/mode inputs and the board LED/ssLED pins.

---
 rtl/key_controller.sv | 139 +++++++++++++
 tb/tb_key_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_controller.sv
// key_controller: synchronises and debounces the two active-low push-buttons
// and turns them into run / clear / mode control for the stopwatch counter.
//   KEY[0]  press  -> toggle run
//   KEY[1]  short  -> clear (only while stopped)
//   KEY[1]  long   -> toggle timer/stopwatch mode, stop, clear

// Per-key 2-FF synchroniser + debouncer with a one-cycle press strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          stable_q;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it holds long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      stable   <= 1'b1;
      stable_q <= 1'b1;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], key_raw};
      stable_q <= stable;
      if (sync[1] == stable)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  // Active-low key: a falling stable level is a press
  assign press = stable_q & ~stable;
endmodule

module key_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  output logic       run,
  output logic       clr,
  output logic       mode,
  output logic [1:0] ss_led
);
  localparam int NUM_KEYS = 2;
  localparam int HW       = $clog2(LONG_CYCLES);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HELD      = 2'd1;
  localparam logic [1:0] LONG_DONE = 2'd2;

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press;
  logic [1:0]          state;
  logic [HW-1:0]       hold;
  logic                led0;
  logic                short_fire;
  logic                long_fire;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (CLOCK_50),
      .rst_n   (RESET_N),
      .key_raw (KEY[k]),
      .stable  (stable[k]),
      .press   (press[k])
    );
  end

  // Classify the KEY[1] hold: released early (short) or held to the limit (long)
  always_comb begin
    short_fire = 1'b0;
    long_fire  = 1'b0;
    if (state == HELD) begin
      short_fire = stable[1];
      long_fire  = ~stable[1] && (hold == HW'(LONG_CYCLES - 1));
    end
  end

  // KEY[1] hold FSM with saturating hold counter
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: if (press[1]) begin
          state <= HELD;
          hold  <= '0;
        end
        HELD: begin
          if (short_fire)
            state <= IDLE;
          else if (long_fire)
            state <= LONG_DONE;
          else if (hold != {HW{1'b1}})
            hold <= hold + 1'b1;
        end
        LONG_DONE: if (stable[1]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs; long press overrides a coincident run toggle, and the
  // short-press clear looks at run before any same-cycle toggle
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      run  <= 1'b0;
      clr  <= 1'b0;
      mode <= 1'b0;
      led0 <= 1'b0;
    end else begin
      led0 <= ~stable[0];
      clr  <= long_fire | (short_fire & ~run);
      if (long_fire) begin
        run  <= 1'b0;
        mode <= ~mode;
      end else if (press[0])
        run <= ~run;
    end
  end

  assign ss_led = {run, led0};
endmodule

// File: tb/tb_key_controller.sv
// Directed bench for key_controller with short debounce/long-press windows.
module tb_key_controller;
  localparam int DB = 4;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic       run, clr, mode;
  logic [1:0] ss_led;

  int checks = 0;
  int errors = 0;

  key_controller #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .run      (run),
    .clr      (clr),
    .mode     (mode),
    .ss_led   (ss_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, counting clr pulses and the cycle of the first one
  task automatic watch_clr(input int n, output int cnt, output int first);
    cnt = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (clr === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic press0(input int hold, input int gap);
    key[0] = 1'b0; tick(hold);
    key[0] = 1'b1; tick(gap);
  endtask

  int n, f, n2, f2;
  logic exp_run;

  initial begin
    rst_n = 1'b0;
    key   = 2'b11;
    tick(3);
    chk("rst_run",  run,    0);
    chk("rst_clr",  clr,    0);
    chk("rst_mode", mode,   0);
    chk("rst_led",  ss_led, 0);
    rst_n = 1'b1;
    tick(3);

    // 3-cycle bounce on KEY[0] must be rejected
    key[0] = 1'b0; tick(3);
    key[0] = 1'b1; tick(10);
    chk("bounce_run", run,    0);
    chk("bounce_led", ss_led, 0);

    // Clean press: run rises exactly 2+DB+1 cycles after the raw edge
    key[0] = 1'b0;
    tick(6);
    chk("press_run_early", run, 0);
    tick(1);
    chk("press_run_exact", run,    1);
    chk("press_led",       ss_led, 2'b11);
    tick(3);
    key[0] = 1'b1; tick(10);
    chk("release_run", run,    1);
    chk("release_led", ss_led, 2'b10);

    // Short KEY[1] press while running: no clear
    key[1] = 1'b0; tick(8);
    key[1] = 1'b1;
    watch_clr(20, n, f);
    chk("short_run1_clr",  n,    0);
    chk("short_run1_mode", mode, 0);
    chk("short_run1_run",  run,  1);

    // Stop, then short press while stopped: one clr 2+DB+1 after release
    press0(10, 10);
    chk("stop_run", run, 0);
    key[1] = 1'b0; tick(8);
    key[1] = 1'b1;
    watch_clr(20, n, f);
    chk("short_run0_cnt",  n,    1);
    chk("short_run0_when", f,    7);
    chk("short_run0_mode", mode, 0);

    // Long press while running: fires at hold count LG-1
    press0(10, 10);
    chk("start_run", run, 1);
    key[1] = 1'b0;
    watch_clr(40, n, f);
    chk("long_cnt",  n,    1);
    chk("long_when", f,    2 + DB + 1 + LG);
    chk("long_mode", mode, 1);
    chk("long_run",  run,  0);
    key[1] = 1'b1;
    watch_clr(20, n, f);
    chk("long_release_clr", n,    0);
    chk("long_release_mode", mode, 1);

    // KEY[0] press strobe coincides with the long-press firing cycle
    key[1] = 1'b0;
    tick(20);
    key[0] = 1'b0;
    tick(7);
    chk("coinc_clr",  clr,  1);
    chk("coinc_run",  run,  0);
    chk("coinc_mode", mode, 0);
    tick(5);
    key = 2'b11;
    watch_clr(20, n, f);
    chk("coinc_after_clr", n,   0);
    chk("coinc_after_run", run, 0);

    // Three alternating presses: run 1,0,1 and never a clear
    n2 = 0;
    exp_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key[0] = 1'b0;
      watch_clr(10, n, f); n2 += n;
      key[0] = 1'b1;
      watch_clr(10, n, f); n2 += n;
      exp_run = ~exp_run;
      chk($sformatf("alt_run%0d", i), run, exp_run);
    end
    chk("alt_clr", n2, 0);

    // Asynchronous reset mid-operation, key held down
    key[0] = 1'b0;
    tick(8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run",  run,    0);
    chk("arst_led",  ss_led, 0);
    chk("arst_mode", mode,   0);
    chk("arst_clr",  clr,    0);
    key = 2'b11;
    tick(2);
    rst_n = 1'b1;
    watch_clr(10, f2, f);
    chk("post_arst_clr", f2,  0);
    chk("post_arst_run", run, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
